// File: rtl/decoder2_4_sequential.sv
// rtl/decoder2_4_sequential.sv - registered 2-to-4 decoder with valid/ready input and programmable hold
//
// Optional feature macro: DEC2_4_EVENT_COUNT_EN (enables the dec_count event counter).
//
// Parameters:
//   HOLD_CYCLES  cycles the selected Y line stays high (1..255)
//   CNT_W        width of dec_count
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   en         block enable; low blocks acceptance and aborts an active hold
//   in_valid   code on A1,A0 is valid
//   A1, A0     code to decode, A1 is the MSB
//   in_ready   combinational: en and idle
//   Y3..Y0     registered one-hot outputs, zero when not holding
//   busy       registered, high while holding
//   done       registered one-cycle pulse after a normal hold completion
//   dec_count  accepted-transfer count (tied to 0 without the macro)

module decoder2_4_sequential #(
    parameter int HOLD_CYCLES = 4,
    parameter int CNT_W       = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             in_valid,
    input  logic             A1,
    input  logic             A0,
    output logic             in_ready,
    output logic             Y3,
    output logic             Y2,
    output logic             Y1,
    output logic             Y0,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] dec_count
);

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t      state_q, state_d;
    logic [7:0]  hold_cnt_q, hold_cnt_d;
    logic [1:0]  code_q, code_d;
    logic [3:0]  y_q, y_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;

    assign in_ready = en && (state_q == IDLE);

    always_comb begin
        state_d    = state_q;
        hold_cnt_d = hold_cnt_q;
        code_d     = code_q;
        y_d        = y_q;
        busy_d     = busy_q;
        done_d     = 1'b0;

        case (state_q)
            IDLE: begin
                y_d    = 4'b0000;
                busy_d = 1'b0;
                if (in_valid && in_ready) begin
                    code_d     = {A1, A0};
                    // Counter counts the remaining hold cycles after the first one.
                    hold_cnt_d = 8'(HOLD_CYCLES - 1);
                    state_d    = HOLD;
                    y_d        = 4'b0001 << {A1, A0};
                    busy_d     = 1'b1;
                end
            end
            HOLD: begin
                if (!en) begin
                    // Abort: enable wins over completion, and no done pulse.
                    state_d = IDLE;
                    y_d     = 4'b0000;
                    busy_d  = 1'b0;
                end else if (hold_cnt_q != 8'd0) begin
                    hold_cnt_d = hold_cnt_q - 8'd1;
                end else begin
                    state_d = IDLE;
                    y_d     = 4'b0000;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                y_d     = 4'b0000;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            hold_cnt_q <= 8'd0;
            code_q     <= 2'b00;
            y_q        <= 4'b0000;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            hold_cnt_q <= hold_cnt_d;
            code_q     <= code_d;
            y_q        <= y_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign Y3   = y_q[3];
    assign Y2   = y_q[2];
    assign Y1   = y_q[1];
    assign Y0   = y_q[0];
    assign busy = busy_q;
    assign done = done_q;

`ifdef DEC2_4_EVENT_COUNT_EN
    logic [CNT_W-1:0] dec_count_q, dec_count_d;
    logic             xfer;

    assign xfer = in_valid && in_ready;

    always_comb begin
        dec_count_d = dec_count_q;
        if (xfer) begin
            // Natural modulo-2^CNT_W wrap.
            dec_count_d = dec_count_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            dec_count_q <= '0;
        end else begin
            dec_count_q <= dec_count_d;
        end
    end

    assign dec_count = dec_count_q;
`else
    assign dec_count = '0;
`endif

endmodule

// File: tb/tb_decoder2_4_sequential.sv
// tb/tb_decoder2_4_sequential.sv - self-checking bench for decoder2_4_sequential

module tb_decoder2_4_sequential;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst, en, in_valid, A1, A0;

    // Instance 0: HOLD_CYCLES=4, CNT_W=8. Instance 1: HOLD_CYCLES=1, CNT_W=2.
    logic [1:0]      rdy_o, busy_o, done_o;
    logic [1:0][3:0] y_o;
    logic [7:0]      cnt0;
    logic [1:0]      cnt1;

    decoder2_4_sequential #(.HOLD_CYCLES(4), .CNT_W(8)) u_dut0 (
        .clk(clk), .rst(rst), .en(en), .in_valid(in_valid), .A1(A1), .A0(A0),
        .in_ready(rdy_o[0]), .Y3(y_o[0][3]), .Y2(y_o[0][2]), .Y1(y_o[0][1]), .Y0(y_o[0][0]),
        .busy(busy_o[0]), .done(done_o[0]), .dec_count(cnt0)
    );

    decoder2_4_sequential #(.HOLD_CYCLES(1), .CNT_W(2)) u_dut1 (
        .clk(clk), .rst(rst), .en(en), .in_valid(in_valid), .A1(A1), .A0(A0),
        .in_ready(rdy_o[1]), .Y3(y_o[1][3]), .Y2(y_o[1][2]), .Y1(y_o[1][1]), .Y0(y_o[1][0]),
        .busy(busy_o[1]), .done(done_o[1]), .dec_count(cnt1)
    );

    int tests = 0;
    int fails = 0;
    int cyc   = 0;
    bit chk_en = 1'b0;

    // Timeline model: a hold is just "Y[code] high from the cycle after
    // acceptance through cycle hold_end", done is expected in one cycle number.
    int        HC[2]    = '{4, 1};
    int        CMOD[2]  = '{256, 4};
    bit        hvalid[2];
    int        hend[2];
    logic [1:0] mcode[2];
    int        done_at[2];
    int        mcount[2];
    bit        acc0;

    task automatic check(input string tag, input int inst, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s[%0d] cyc=%0d observed=%0h expected=%0h", tag, inst, cyc, obs, exp);
        end
    endtask

    task automatic step(input bit r, input bit e, input bit v, input logic [1:0] code);
        bit         holding;
        bit         exp_rdy;
        logic [3:0] exp_y;
        int         exp_cnt;
        logic [31:0] obs_cnt;
        rst = r; en = e; in_valid = v; {A1, A0} = code;
        @(negedge clk);
        acc0 = 1'b0;
        for (int i = 0; i < 2; i++) begin
            holding = hvalid[i] && (cyc <= hend[i]);
            exp_y   = holding ? (4'b0001 << mcode[i]) : 4'b0000;
            exp_rdy = e && !holding;
`ifdef DEC2_4_EVENT_COUNT_EN
            exp_cnt = mcount[i];
`else
            exp_cnt = 0;
`endif
            obs_cnt = (i == 0) ? {24'd0, cnt0} : {30'd0, cnt1};
            if (chk_en) begin
                check("Y", i, {28'd0, y_o[i]}, {28'd0, exp_y});
                check("busy", i, {31'd0, busy_o[i]}, {31'd0, holding});
                check("done", i, {31'd0, done_o[i]}, {31'd0, (cyc == done_at[i])});
                check("in_ready", i, {31'd0, rdy_o[i]}, {31'd0, exp_rdy});
                check("dec_count", i, obs_cnt, exp_cnt);
            end
            // Effect of this cycle on the following ones.
            if (r) begin
                hvalid[i]  = 1'b0;
                done_at[i] = -1;
                mcount[i]  = 0;
            end else if (holding) begin
                if (!e) hvalid[i] = 1'b0;
                else if (cyc == hend[i]) done_at[i] = cyc + 1;
            end else if (exp_rdy && v) begin
                hvalid[i] = 1'b1;
                hend[i]   = cyc + HC[i];
                mcode[i]  = code;
                mcount[i] = (mcount[i] + 1) % CMOD[i];
                if (i == 0) acc0 = 1'b1;
            end
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // Holds in_valid until instance 0 accepts, bounded.
    task automatic send(input logic [1:0] code);
        int n = 0;
        do begin
            step(1'b0, 1'b1, 1'b1, code);
            n++;
        end while (!acc0 && n < 20);
        tests++;
        assert (acc0) else begin
            fails++;
            $error("FAIL send_timeout code=%0d observed=not_accepted expected=accepted", code);
        end
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(1'b0, 1'b1, 1'b0, 2'b00);
    endtask

    initial begin
        for (int i = 0; i < 2; i++) begin
            hvalid[i] = 1'b0; hend[i] = 0; mcode[i] = 2'b00; done_at[i] = -1; mcount[i] = 0;
        end
        rst = 1'b1; en = 1'b0; in_valid = 1'b0; A1 = 1'b0; A0 = 1'b0;
        @(posedge clk); #1;
        step(1'b1, 1'b0, 1'b0, 2'b00);
        chk_en = 1'b1;
        step(1'b1, 1'b1, 1'b0, 2'b00);

        // Single code 10.
        idle(1);
        send(2'b10);
        idle(7);

        // All four codes back-to-back with valid held high.
        for (int c = 0; c < 4; c++) send(2'(c));
        idle(7);

        // Abort in the 2nd hold cycle of code 01.
        send(2'b01);
        idle(1);
        for (int k = 0; k < 3; k++) step(1'b0, 1'b0, 1'b1, 2'b01);
        idle(3);

        // Reset in the 3rd hold cycle of code 00, then a normal hold.
        send(2'b00);
        idle(2);
        step(1'b1, 1'b1, 1'b0, 2'b00);
        send(2'b00);
        idle(7);

        // Randomized phase.
        for (int k = 0; k < 600; k++) begin
            step(($urandom_range(0, 99) < 2), ($urandom_range(0, 99) < 85),
                 ($urandom_range(0, 99) < 60), 2'($urandom_range(0, 3)));
        end
        idle(6);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
